// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator call scheduler.
package elevator_pkg;
    localparam int unsigned DEF_FLOORS  = 8;
    localparam int unsigned DEF_FLOOR_W = 3;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        SERVE,
        DOOR
    } state_t;
endpackage

// File: rtl/floor_search.sv
// Combinational nearest/farthest set-bit search above and below a floor index.
module floor_search
    import elevator_pkg::*;
#(
    parameter int unsigned FLOORS  = DEF_FLOORS,
    parameter int unsigned FLOOR_W = DEF_FLOOR_W
) (
    input  logic [FLOORS-1:0]  mask,
    input  logic [FLOOR_W-1:0] floor_idx,
    output logic [FLOOR_W-1:0] lo_above,
    output logic [FLOOR_W-1:0] hi_above,
    output logic               found_above,
    output logic [FLOOR_W-1:0] lo_below,
    output logic [FLOOR_W-1:0] hi_below,
    output logic               found_below
);
    logic idx_valid;

    always_comb begin
        idx_valid   = 1'b0;
        lo_above    = '0;
        hi_above    = '0;
        found_above = 1'b0;
        lo_below    = '0;
        hi_below    = '0;
        found_below = 1'b0;
        for (int unsigned f = 0; f < FLOORS; f++) begin
            if (floor_idx == FLOOR_W'(f)) idx_valid = 1'b1;
        end
        // Ascending scan: the first hit fixes the lowest, every later hit overwrites the highest.
        for (int unsigned f = 0; f < FLOORS; f++) begin
            if (idx_valid && mask[f]) begin
                if (FLOOR_W'(f) > floor_idx) begin
                    if (!found_above) lo_above = FLOOR_W'(f);
                    hi_above    = FLOOR_W'(f);
                    found_above = 1'b1;
                end else if (FLOOR_W'(f) < floor_idx) begin
                    if (!found_below) lo_below = FLOOR_W'(f);
                    hi_below    = FLOOR_W'(f);
                    found_below = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/call_scheduler.sv
// Hall/car call latch and SCAN target selection feeding the motion and door FSM.
module call_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned FLOORS  = DEF_FLOORS,
    parameter int unsigned FLOOR_W = DEF_FLOOR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOORS-1:0]  btn_in,
    input  logic [FLOORS-1:0]  btn_up_out,
    input  logic [FLOORS-1:0]  btn_down_out,
    input  logic [FLOOR_W-1:0] car_floor,
    input  logic               arrive,
    input  logic               door_done,
    output logic               target_valid,
    output logic [FLOOR_W-1:0] target_floor,
    output logic               dir_up,
    output logic               door_open_req,
    output logic [FLOORS-1:0]  pend_in,
    output logic [FLOORS-1:0]  pend_up,
    output logic [FLOORS-1:0]  pend_down
);
    localparam logic [FLOORS-1:0] UP_OK = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0] DN_OK = {{(FLOORS-1){1'b1}}, 1'b0};

    state_t state;

    logic [FLOORS-1:0]  here;
    logic [FLOORS-1:0]  mask_iu, mask_id;
    logic [FLOORS-1:0]  clr_in, clr_up, clr_dn;
    logic [FLOOR_W-1:0] iu_lo_above, iu_hi_above, iu_lo_below, iu_hi_below;
    logic [FLOOR_W-1:0] id_lo_above, id_hi_above, id_lo_below, id_hi_below;
    logic               iu_fa, iu_fb, id_fa, id_fb;
    logic               ahead_up, ahead_dn, ahead, behind;
    logic               at_in, at_fwd, at_rev;
    logic [FLOOR_W-1:0] tgt_up, tgt_dn, tgt_fwd, tgt_rev;
    logic               unused_search;

    always_comb begin
        here = '0;
        for (int unsigned f = 0; f < FLOORS; f++) begin
            if (car_floor == FLOOR_W'(f)) here[f] = 1'b1;
        end
    end

    assign mask_iu = pend_in | pend_up;
    assign mask_id = pend_in | pend_down;

    floor_search #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) u_search_iu (
        .mask        (mask_iu),
        .floor_idx   (car_floor),
        .lo_above    (iu_lo_above),
        .hi_above    (iu_hi_above),
        .found_above (iu_fa),
        .lo_below    (iu_lo_below),
        .hi_below    (iu_hi_below),
        .found_below (iu_fb)
    );

    floor_search #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) u_search_id (
        .mask        (mask_id),
        .floor_idx   (car_floor),
        .lo_above    (id_lo_above),
        .hi_above    (id_hi_above),
        .found_above (id_fa),
        .lo_below    (id_lo_below),
        .hi_below    (id_hi_below),
        .found_below (id_fb)
    );

    assign unused_search = ^{iu_hi_above, iu_hi_below, id_lo_above, id_lo_below};

    // When no car/up call lies above, the highest in|down hit above is a pure down call (mirrored below).
    assign tgt_up   = iu_fa ? iu_lo_above : id_hi_above;
    assign tgt_dn   = id_fb ? id_hi_below : iu_lo_below;
    assign ahead_up = iu_fa | id_fa;
    assign ahead_dn = iu_fb | id_fb;

    assign ahead   = (dir_up == DIR_UP) ? ahead_up : ahead_dn;
    assign behind  = (dir_up == DIR_UP) ? ahead_dn : ahead_up;
    assign tgt_fwd = (dir_up == DIR_UP) ? tgt_up : tgt_dn;
    assign tgt_rev = (dir_up == DIR_UP) ? tgt_dn : tgt_up;
    assign at_in   = |(pend_in & here);
    assign at_fwd  = (dir_up == DIR_UP) ? |(pend_up & here) : |(pend_down & here);
    assign at_rev  = (dir_up == DIR_UP) ? |(pend_down & here) : |(pend_up & here);

    always_comb begin
        clr_in = '0;
        clr_up = '0;
        clr_dn = '0;
        if (state == SERVE) begin
            clr_in = here;
            if (dir_up == DIR_UP || !ahead) clr_up = here;
            if (dir_up == DIR_DOWN || !ahead) clr_dn = here;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pend_in       <= '0;
            pend_up       <= '0;
            pend_down     <= '0;
            target_valid  <= 1'b0;
            target_floor  <= '0;
            dir_up        <= DIR_UP;
            door_open_req <= 1'b0;
        end else begin
            pend_in       <= (pend_in | btn_in) & ~clr_in;
            pend_up       <= (pend_up | btn_up_out) & ~clr_up & UP_OK;
            pend_down     <= (pend_down | btn_down_out) & ~clr_dn & DN_OK;
            door_open_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (at_in || at_fwd) begin
                        state <= SERVE;
                    end else if (ahead) begin
                        state        <= MOVE;
                        target_valid <= 1'b1;
                        target_floor <= tgt_fwd;
                    end else if (behind) begin
                        state        <= MOVE;
                        dir_up       <= (dir_up == DIR_UP) ? DIR_DOWN : DIR_UP;
                        target_valid <= 1'b1;
                        target_floor <= tgt_rev;
                    end else if (at_rev) begin
                        state  <= SERVE;
                        dir_up <= (dir_up == DIR_UP) ? DIR_DOWN : DIR_UP;
                    end
                end
                MOVE: begin
                    if (arrive && car_floor == target_floor) begin
                        state        <= SERVE;
                        target_valid <= 1'b0;
                    end else if (!ahead) begin
                        state        <= IDLE;
                        target_valid <= 1'b0;
                    end else begin
                        target_floor <= tgt_fwd;
                    end
                end
                SERVE: begin
                    door_open_req <= 1'b1;
                    if (!ahead) dir_up <= (dir_up == DIR_UP) ? DIR_DOWN : DIR_UP;
                    state <= DOOR;
                end
                DOOR: begin
                    if (door_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
